// File: rtl/seq_mul_unit.sv
// seq_mul_unit: iterative radix-2 shift-add 64x64 multiplier for MUL, UMULH and SMULH.
// Ports: Clk/Resetb/Flush, Start/Op/A/B/RdIn in; Busy/Done/Result/RdOut/RegWrOut out.
module seq_mul_unit #(
    parameter int WIDTH = 64,
    parameter int CNTW  = 6
) (
    input  logic             Clk,
    input  logic             Resetb,
    input  logic             Flush,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       RdIn,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [4:0]       RdOut,
    output logic             RegWrOut
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_SIGN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [1:0]         op_q;
    logic [4:0]         rd_q;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod;
    logic [CNTW-1:0]    cnt;
    logic               neg;

    logic               accept;
    logic               last;
    logic               is_smulh;
    logic               hi_sel;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod_fin;

    assign accept   = (state == S_IDLE || state == S_DONE) && Start && !Flush;
    assign last     = (cnt == CNTW'(WIDTH - 1));
    assign is_smulh = (Op == 2'b10);
    assign hi_sel   = (op_q == 2'b01) || (op_q == 2'b10);

    // Magnitudes only for SMULH; -2^63 maps to 2^63, which fits unsigned.
    assign a_mag = (is_smulh && A[WIDTH-1]) ? -A : A;
    assign b_mag = (is_smulh && B[WIDTH-1]) ? -B : B;

    // Upper-half add keeps its carry, which becomes the top bit after the shift.
    assign sum = {1'b0, prod[2*WIDTH-1:WIDTH]}
               + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};

    assign prod_fin = neg ? -prod : prod;

    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (Flush) begin
            state_nx = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (Start) state_nx = S_MULT;
                S_MULT:  if (last) state_nx = S_SIGN;
                S_SIGN:  state_nx = S_DONE;
                S_DONE:  state_nx = Start ? S_MULT : S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            op_q   <= 2'b00;
            rd_q   <= 5'd0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            Result <= '0;
            RdOut  <= 5'd0;
        end else if (accept) begin
            op_q   <= Op;
            rd_q   <= RdIn;
            mcand  <= a_mag;
            mplier <= b_mag;
            prod   <= '0;
            cnt    <= '0;
            neg    <= is_smulh && (A[WIDTH-1] ^ B[WIDTH-1]);
        end else if (!Flush && state == S_MULT) begin
            prod   <= {sum, prod[WIDTH-1:1]};
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end else if (!Flush && state == S_SIGN) begin
            prod   <= prod_fin;
            Result <= hi_sel ? prod_fin[2*WIDTH-1:WIDTH]
                             : prod_fin[WIDTH-1:0];
            RdOut  <= rd_q;
        end
    end

    assign Busy     = (state == S_MULT) || (state == S_SIGN);
    assign Done     = (state == S_DONE);
    assign RegWrOut = Done && (RdOut != 5'd31);

endmodule

// File: tb/tb_seq_mul_unit.sv
// tb_seq_mul_unit: directed self-checking bench for seq_mul_unit.
// Drives ops, checks latency, results, handshake, flush and async reset.
module tb_seq_mul_unit;

    logic        Clk = 1'b0;
    logic        Resetb;
    logic        Flush;
    logic        Start;
    logic [1:0]  Op;
    logic [63:0] A;
    logic [63:0] B;
    logic [4:0]  RdIn;
    logic        Busy;
    logic        Done;
    logic [63:0] Result;
    logic [4:0]  RdOut;
    logic        RegWrOut;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    seq_mul_unit #(.WIDTH(64), .CNTW(6)) dut (
        .Clk      (Clk),
        .Resetb   (Resetb),
        .Flush    (Flush),
        .Start    (Start),
        .Op       (Op),
        .A        (A),
        .B        (B),
        .RdIn     (RdIn),
        .Busy     (Busy),
        .Done     (Done),
        .Result   (Result),
        .RdOut    (RdOut),
        .RegWrOut (RegWrOut)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] op, input logic [63:0] a,
                            input logic [63:0] b, input logic [4:0] rd);
        Op    = op;
        A     = a;
        B     = b;
        RdIn  = rd;
        Start = 1'b1;
    endtask

    // Accept edge is the next posedge; Done must appear 65 edges later.
    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        @(posedge Clk);
        #1 Start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge Clk);
            #1;
            if (Done) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_lat"}, 64'(lat), 64'd65);
    endtask

    initial begin
        int  busy_ok;
        int  seen;

        Resetb = 1'b0;
        Flush  = 1'b0;
        Start  = 1'b0;
        Op     = 2'b00;
        A      = '0;
        B      = '0;
        RdIn   = 5'd0;

        #12;
        chk("rst_ctl", 64'({Busy, Done, RegWrOut}), 64'd0);
        chk("rst_res", Result, 64'd0);
        chk("rst_rd", 64'(RdOut), 64'd0);
        @(negedge Clk);
        Resetb = 1'b1;
        @(posedge Clk);
        #1;

        // MUL 3x5
        start_op(2'b00, 64'd3, 64'd5, 5'd2);
        wait_done("mul35");
        chk("mul35_res", Result, 64'd15);
        chk("mul35_rd", 64'(RdOut), 64'd2);
        chk("mul35_wr", 64'(RegWrOut), 64'd1);
        chk("mul35_busy", 64'(Busy), 64'd0);
        @(posedge Clk);
        #1;
        chk("done_pulse", 64'(Done), 64'd0);

        // Remaining ops issued back-to-back from the DONE cycle.
        start_op(2'b01, ONES, ONES, 5'd5);
        wait_done("umulh");
        chk("umulh_res", Result, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("umulh_rd", 64'(RdOut), 64'd5);

        start_op(2'b00, ONES, ONES, 5'd6);
        wait_done("mulff");
        chk("mulff_res", Result, 64'd1);

        start_op(2'b10, ONES, 64'd2, 5'd7);
        wait_done("smulh_m1");
        chk("smulh_m1_res", Result, ONES);

        start_op(2'b10, 64'h8000_0000_0000_0000,
                 64'h8000_0000_0000_0000, 5'd8);
        wait_done("smulh_min");
        chk("smulh_min_res", Result, 64'h4000_0000_0000_0000);

        start_op(2'b11, 64'd3, 64'd4, 5'd9);
        wait_done("rsvd");
        chk("rsvd_res", Result, 64'd12);
        chk("rsvd_rd", 64'(RdOut), 64'd9);
        @(posedge Clk);
        #1;

        // Start pulses at E10 and E40 must be ignored.
        start_op(2'b00, 64'd6, 64'd7, 5'd4);
        @(posedge Clk);
        #1 Start = 1'b0;
        busy_ok = 1;
        for (int k = 1; k <= 65; k++) begin
            @(posedge Clk);
            #1;
            if (k <= 64 && !Busy) busy_ok = 0;
            if (k == 9 || k == 39) start_op(2'b01, ONES, 64'd100, 5'd9);
            if (k == 10 || k == 40) Start = 1'b0;
        end
        chk("ign_busy_hold", 64'(busy_ok), 64'd1);
        chk("ign_done", 64'(Done), 64'd1);
        chk("ign_busy_end", 64'(Busy), 64'd0);
        chk("ign_res", Result, 64'd42);
        chk("ign_rd", 64'(RdOut), 64'd4);
        @(posedge Clk);
        #1;
        chk("ign_pulse", 64'(Done), 64'd0);

        // Flush at E30.
        start_op(2'b00, 64'd9, 64'd9, 5'd3);
        @(posedge Clk);
        #1 Start = 1'b0;
        for (int k = 1; k <= 29; k++) @(posedge Clk);
        #1 Flush = 1'b1;
        @(posedge Clk);
        #1 Flush = 1'b0;
        chk("flush_busy", 64'(Busy), 64'd0);
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge Clk);
            #1;
            if (Done) seen = 1;
        end
        chk("flush_nodone", 64'(seen), 64'd0);
        chk("flush_res", Result, 64'd42);

        // Async reset mid-MULT.
        start_op(2'b01, ONES, ONES, 5'd7);
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (20) @(posedge Clk);
        #2 Resetb = 1'b0;
        #1;
        chk("arst_ctl", 64'({Busy, Done, RegWrOut}), 64'd0);
        chk("arst_res", Result, 64'd0);
        chk("arst_rd", 64'(RdOut), 64'd0);
        @(negedge Clk);
        Resetb = 1'b1;
        seen = 0;
        for (int k = 0; k < 70; k++) begin
            @(posedge Clk);
            #1;
            if (Done || Busy) seen = 1;
        end
        chk("arst_idle", 64'(seen), 64'd0);

        // Rd=31 computes but does not write.
        start_op(2'b00, 64'd7, 64'd7, 5'd31);
        wait_done("xzr");
        chk("xzr_res", Result, 64'd49);
        chk("xzr_rd", 64'(RdOut), 64'd31);
        chk("xzr_wr", 64'(RegWrOut), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
